// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared syscall codes and syscall FSM state type
package mips_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SYS_EXIT2      = 32'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT,
    ST_STR_REQ,
    ST_STR_EMIT,
    ST_HALTED
  } sys_state_e;

  function automatic logic sys_code_ok(input logic [31:0] code);
    return (code == SYS_PRINT_INT) || (code == SYS_PRINT_STR) || (code == SYS_EXIT) ||
           (code == SYS_PRINT_CHAR) || (code == SYS_EXIT2);
  endfunction

endpackage

// File: rtl/syscall_byte_sel.sv
// rtl/syscall_byte_sel.sv - big-endian byte extract, index 0 is the most significant byte
module syscall_byte_sel #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_idx,
  output logic [7:0]        o_byte
);

  localparam int LAST = DATA_W / 8 - 1;

  assign o_byte = 8'(i_word >> (8 * (LAST - int'(i_idx))));

endmodule

// File: rtl/syscall_unit.sv
// rtl/syscall_unit.sv - stalling syscall engine with console stream and string fetch
// Optional SYSCALL_SIM_DISPLAY_EN adds simulation-only console echo and $finish on exit.
module syscall_unit
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MAX_STR_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              syscall_control,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              sysstall,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_int,
  output logic              halt,
  output logic [DATA_W-1:0] exit_code
);

  localparam int LEN_W = $clog2(MAX_STR_LEN + 1);

  sys_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_word, r_arg, r_exit_code;
  logic              r_is_int, r_done, r_err;
  logic [7:0]        w_byte;
  logic              w_str_end;

  syscall_byte_sel #(.DATA_W(DATA_W)) u_byte_sel (
    .i_word (r_word),
    .i_idx  (r_ptr[1:0]),
    .o_byte (w_byte)
  );

  assign w_str_end = (w_byte == 8'h00) || (r_len == LEN_W'(MAX_STR_LEN));
  assign mem_addr  = {r_ptr[ADDR_W-1:2], 2'b00};
  assign done      = r_done;
  assign err       = r_err;
  assign exit_code = r_exit_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    sysstall   = (r_state != ST_IDLE);
    mem_req    = 1'b0;
    out_valid  = 1'b0;
    out_data   = r_arg;
    out_is_int = 1'b0;
    halt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (syscall_control) begin
          sysstall = sys_code_ok(v0);
          case (v0)
            SYS_PRINT_INT, SYS_PRINT_CHAR: w_next = ST_EMIT;
            SYS_PRINT_STR:                 w_next = ST_STR_REQ;
            SYS_EXIT, SYS_EXIT2:           w_next = ST_HALTED;
            default:                       w_next = ST_IDLE;
          endcase
        end
      end
      ST_EMIT: begin
        out_valid  = 1'b1;
        out_is_int = r_is_int;
        if (out_ready) w_next = ST_IDLE;
      end
      ST_STR_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) w_next = ST_STR_EMIT;
      end
      ST_STR_EMIT: begin
        out_data = {{(DATA_W-8){1'b0}}, w_byte};
        if (w_str_end) begin
          w_next = ST_IDLE;
        end else begin
          out_valid = 1'b1;
          // Last byte of the word accepted: the next byte lives in a fresh word.
          if (out_ready && (r_ptr[1:0] == 2'b11)) w_next = ST_STR_REQ;
        end
      end
      ST_HALTED: halt = 1'b1;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_len       <= '0;
      r_word      <= '0;
      r_arg       <= '0;
      r_exit_code <= '0;
      r_is_int    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (syscall_control) begin
            case (v0)
              SYS_PRINT_INT: begin
                r_arg    <= a0;
                r_is_int <= 1'b1;
              end
              SYS_PRINT_CHAR: begin
                r_arg    <= {{(DATA_W-8){1'b0}}, a0[7:0]};
                r_is_int <= 1'b0;
              end
              SYS_PRINT_STR: begin
                r_ptr <= ADDR_W'(a0);
                r_len <= '0;
              end
              SYS_EXIT:  r_exit_code <= '0;
              SYS_EXIT2: r_exit_code <= a0;
              default: begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
              end
            endcase
          end
        end
        ST_EMIT: if (out_ready) r_done <= 1'b1;
        ST_STR_REQ: if (mem_ack) r_word <= mem_rdata;
        ST_STR_EMIT: begin
          if (w_str_end) begin
            r_done <= 1'b1;
          end else if (out_ready) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            r_len <= r_len + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SYSCALL_SIM_DISPLAY_EN
  string r_sim_str;
  logic  r_sim_halted;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sim_str    = "";
      r_sim_halted = 1'b0;
    end else begin
      if (r_state == ST_EMIT && out_ready && r_is_int)
        $display("%0d", $signed(r_arg));
      if (r_state == ST_STR_EMIT && !w_str_end && out_ready)
        r_sim_str = $sformatf("%s%c", r_sim_str, w_byte);
      if (r_state == ST_STR_EMIT && w_str_end) begin
        $display("%s", r_sim_str);
        r_sim_str = "";
      end
      if (r_state == ST_HALTED) begin
        if (r_sim_halted) $finish;
        else $display("program exited with code %0d", r_exit_code);
        r_sim_halted = 1'b1;
      end
    end
  end
`endif

endmodule
